// File: rtl/multi_tick_divider.sv
// multi_tick_divider
//   Multi-channel programmable tick divider. Each channel divides clk_in by
//   (D+1) and emits a registered one-cycle tick per period. Divisor writes are
//   double-buffered and only take effect at a period boundary, on a disabled
//   channel's next edge, or on sync_restart, so a running channel never sees
//   a truncated or stretched period.
//
//   Optional feature macro: MULTI_TICK_DIVIDER_SQUARE_EN
//     defined   -> per-channel 50% duty square output (toggles on each tick)
//     undefined -> sq_out is tied to 0; tick/write/restart unchanged
//
//   Reset: rst, asynchronous, active-high. Clock: clk_in, rising edge.

module multi_tick_divider #(
    parameter int                CHANNELS    = 2,
    parameter int                WIDTH       = 16,
    parameter int                SEL_W       = 1,
    parameter logic [WIDTH-1:0]  DEFAULT_DIV = WIDTH'(1)
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [CHANNELS-1:0]  enable,
    input  logic                 sync_restart,
    input  logic                 div_wr,
    input  logic [SEL_W-1:0]     div_sel,
    input  logic [WIDTH-1:0]     div_data,
    output logic [CHANNELS-1:0]  tick_out,
    output logic [CHANNELS-1:0]  sq_out,
    output logic [CHANNELS-1:0]  pending_out
);

    // Write select widened once so it can be compared against any channel
    // index. A select that matches no channel (>= CHANNELS) simply hits
    // nothing, which is how out-of-range writes are ignored.
    logic [31:0] w_sel_ext;
    assign w_sel_ext = 32'(div_sel);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch

        // Registered channel state
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_div_act;
        logic [WIDTH-1:0] r_div_pend;
        logic             r_pend_v;
        logic             r_tick;

        // Decoded per-channel conditions and next-state values
        logic             w_wr_hit;
        logic             w_terminal;
        logic             w_apply;
        logic [WIDTH-1:0] w_cnt_nxt;
        logic [WIDTH-1:0] w_div_act_nxt;
        logic [WIDTH-1:0] w_div_pend_nxt;
        logic             w_pend_v_nxt;
        logic             w_tick_nxt;

        assign w_wr_hit   = div_wr && (w_sel_ext == 32'(ch));
        // The counter never passes div_act, so equality is the only
        // terminal condition; a larger divisor can never be skipped over.
        assign w_terminal = (r_cnt == r_div_act);

        // Counter, tick and apply decision; sync_restart outranks enable
        // and terminal count.
        always_comb begin
            // NOTE: every signal written here gets a default first, so no
            // path through the branches can leave it unassigned (no latch).
            w_cnt_nxt  = r_cnt;
            w_tick_nxt = 1'b0;
            w_apply    = 1'b0;

            if (sync_restart) begin
                w_cnt_nxt = '0;
                w_apply   = r_pend_v;
            end else if (enable[ch]) begin
                if (w_terminal) begin
                    w_cnt_nxt  = '0;
                    w_tick_nxt = 1'b1;
                    w_apply    = r_pend_v;
                end else begin
                    w_cnt_nxt  = r_cnt + 1'b1;
                end
            end else if (r_pend_v) begin
                // A stopped channel has no period to protect, so a pending
                // divisor is taken immediately and the phase restarts at 0.
                w_cnt_nxt = '0;
                w_apply   = 1'b1;
            end
        end

        // Divisor double-buffer: the apply always uses the value pending
        // before this edge; a write on the same edge refills the buffer.
        always_comb begin
            w_div_act_nxt  = w_apply ? r_div_pend : r_div_act;
            w_div_pend_nxt = r_div_pend;
            w_pend_v_nxt   = r_pend_v && !w_apply;

            if (w_wr_hit) begin
                w_div_pend_nxt = div_data;
                w_pend_v_nxt   = 1'b1;
            end
        end

        // Channel state register
        always_ff @(posedge clk_in or posedge rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            if (rst) begin
                r_cnt      <= '0;
                r_div_act  <= DEFAULT_DIV;
                r_div_pend <= DEFAULT_DIV;
                r_pend_v   <= 1'b0;
                r_tick     <= 1'b0;
            end else begin
                r_cnt      <= w_cnt_nxt;
                r_div_act  <= w_div_act_nxt;
                r_div_pend <= w_div_pend_nxt;
                r_pend_v   <= w_pend_v_nxt;
                r_tick     <= w_tick_nxt;
            end
        end

        assign tick_out[ch]    = r_tick;
        assign pending_out[ch] = r_pend_v;

`ifdef MULTI_TICK_DIVIDER_SQUARE_EN
        logic r_sq;

        // Square output: cleared by restart, toggled on each enabled
        // terminal count, held while the channel is disabled.
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                r_sq <= 1'b0;
            end else if (sync_restart) begin
                r_sq <= 1'b0;
            end else if (enable[ch] && w_terminal) begin
                r_sq <= ~r_sq;
            end
        end

        assign sq_out[ch] = r_sq;
`else
        assign sq_out[ch] = 1'b0;
`endif

    end : g_ch

endmodule : multi_tick_divider

// File: tb/tb_multi_tick_divider.sv
// tb_multi_tick_divider
//   Directed bench for multi_tick_divider (CHANNELS=2, WIDTH=8, SEL_W=2,
//   DEFAULT_DIV=1). Expected values are hand-derived edge by edge.
//   Square-output expectations follow MULTI_TICK_DIVIDER_SQUARE_EN.

`timescale 1ns/1ps

module tb_multi_tick_divider;

    localparam int CHANNELS = 2;
    localparam int WIDTH    = 8;
    localparam int SEL_W    = 2;

`ifdef MULTI_TICK_DIVIDER_SQUARE_EN
    localparam bit SQ_ON = 1'b1;
`else
    localparam bit SQ_ON = 1'b0;
`endif

    logic                clk_in;
    logic                rst;
    logic [CHANNELS-1:0] enable;
    logic                sync_restart;
    logic                div_wr;
    logic [SEL_W-1:0]    div_sel;
    logic [WIDTH-1:0]    div_data;
    logic [CHANNELS-1:0] tick_out;
    logic [CHANNELS-1:0] sq_out;
    logic [CHANNELS-1:0] pending_out;

    int n_checks = 0;
    int n_pass   = 0;

    multi_tick_divider #(
        .CHANNELS    (CHANNELS),
        .WIDTH       (WIDTH),
        .SEL_W       (SEL_W),
        .DEFAULT_DIV (8'd1)
    ) u_dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .enable       (enable),
        .sync_restart (sync_restart),
        .div_wr       (div_wr),
        .div_sel      (div_sel),
        .div_data     (div_data),
        .tick_out     (tick_out),
        .sq_out       (sq_out),
        .pending_out  (pending_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Advance one rising edge, then settle 1ns so outputs reflect that edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] data);
        div_wr   = 1'b1;
        div_sel  = sel;
        div_data = data;
    endtask

    function automatic logic [1:0] sqx(input logic [1:0] v);
        return SQ_ON ? v : 2'b00;
    endfunction

    logic [31:0] tick_mask;
    logic [31:0] pend_mask;
    logic [1:0]  tk_d0 [8];
    logic [1:0]  pd_d0 [8];
    logic [1:0]  sq_d0 [8];
    logic        tk_ap [9];
    logic        pd_ap [9];
    int          first_tick;

    initial begin
        rst          = 1'b1;
        enable       = 2'b11;
        sync_restart = 1'b0;
        div_wr       = 1'b0;
        div_sel      = '0;
        div_data     = '0;

        // ---------------- reset state ----------------
        step();
        check("rst_tick", 32'(tick_out), 32'd0);
        check("rst_sq",   32'(sq_out),   32'd0);
        check("rst_pend", 32'(pending_out), 32'd0);
        rst = 1'b0;

        // ---------------- DEFAULT_DIV=1: tick every 2nd edge from edge 2 ----
        for (int e = 1; e <= 6; e++) begin
            step();
            check($sformatf("def_tick_e%0d", e), 32'(tick_out), (e % 2 == 0) ? 32'd3 : 32'd0);
            check($sformatf("def_sq_e%0d", e), 32'(sq_out), 32'(sqx(((e / 2) % 2 == 1) ? 2'b11 : 2'b00)));
            check($sformatf("def_pend_e%0d", e), 32'(pending_out), 32'd0);
        end

        // ---------------- ch0 D=4, then write 2 mid-period at cnt=1 --------
        wr(2'd0, 8'd4);
        step();
        check("wr_pend_1cyc", 32'(pending_out), 32'd1);
        div_wr       = 1'b0;
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        check("rs1_tick", 32'(tick_out), 32'd0);
        check("rs1_sq",   32'(sq_out),   32'd0);
        check("rs1_pend", 32'(pending_out), 32'd0);

        tick_mask = 32'h0000_0920;   // ticks at edges 5, 8, 11
        pend_mask = 32'h0000_001C;   // pending at edges 2, 3, 4
        for (int e = 1; e <= 11; e++) begin
            step();
            check($sformatf("midwr_tick0_e%0d", e), 32'(tick_out[0]), 32'(tick_mask[e]));
            check($sformatf("midwr_pend0_e%0d", e), 32'(pending_out[0]), 32'(pend_mask[e]));
            if (e == 1) wr(2'd0, 8'd2);
            if (e == 2) div_wr = 1'b0;
        end

        // ---------------- ch1 disabled at cnt=3, write D=7 -----------------
        wr(2'd1, 8'd5);
        step();
        div_wr       = 1'b0;
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        step();
        step();
        step();
        enable = 2'b01;
        wr(2'd1, 8'd7);
        step();
        div_wr = 1'b0;
        check("dis_pend1_set", 32'(pending_out[1]), 32'd1);
        check("dis_tick1_a",   32'(tick_out[1]), 32'd0);
        step();
        check("dis_pend1_applied", 32'(pending_out[1]), 32'd0);
        check("dis_tick1_b",       32'(tick_out[1]), 32'd0);
        step();
        step();
        check("dis_tick1_c", 32'(tick_out[1]), 32'd0);
        enable = 2'b11;
        for (int r = 1; r <= 9; r++) begin
            step();
            check($sformatf("reen_tick1_r%0d", r), 32'(tick_out[1]), (r == 8) ? 32'd1 : 32'd0);
        end

        // ---------------- sync_restart with D=3 on both channels -----------
        wr(2'd0, 8'd3);
        step();
        check("pre_rs_pend", 32'(pending_out), 32'd1);
        sync_restart = 1'b1;
        wr(2'd1, 8'd3);
        step();
        div_wr = 1'b0;
        check("rs_wr_captured_pend", 32'(pending_out), 32'd2);
        check("rs_a_tick", 32'(tick_out), 32'd0);
        check("rs_a_sq",   32'(sq_out),   32'd0);
        step();
        sync_restart = 1'b0;
        check("rs_b_pend", 32'(pending_out), 32'd0);
        check("rs_b_tick", 32'(tick_out), 32'd0);
        check("rs_b_sq",   32'(sq_out),   32'd0);
        for (int r = 1; r <= 4; r++) begin
            step();
            check($sformatf("align_tick_r%0d", r), 32'(tick_out), (r == 4) ? 32'd3 : 32'd0);
            check($sformatf("align_sq_r%0d", r), 32'(sq_out), 32'(sqx((r == 4) ? 2'b11 : 2'b00)));
        end

        // ---------------- write to div_sel=3: ignored ----------------------
        wr(2'd3, 8'd0);
        for (int r = 5; r <= 8; r++) begin
            step();
            if (r == 5) div_wr = 1'b0;
            check($sformatf("badsel_tick_r%0d", r), 32'(tick_out), (r == 8) ? 32'd3 : 32'd0);
            check($sformatf("badsel_pend_r%0d", r), 32'(pending_out), 32'd0);
            check($sformatf("badsel_sq_r%0d", r), 32'(sq_out), 32'(sqx((r == 8) ? 2'b00 : 2'b11)));
        end

        // ---------------- ch0 D=0: tick continuously high after apply ------
        tk_d0 = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11};
        pd_d0 = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        sq_d0 = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b11, 2'b10, 2'b01};
        wr(2'd0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) div_wr = 1'b0;
            check($sformatf("d0_tick_r%0d", i + 9), 32'(tick_out), 32'(tk_d0[i]));
            check($sformatf("d0_pend_r%0d", i + 9), 32'(pending_out), 32'(pd_d0[i]));
            check($sformatf("d0_sq_r%0d", i + 9), 32'(sq_out), 32'(sqx(sq_d0[i])));
        end

        // ---------------- write coincident with apply edge -----------------
        tk_ap = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        pd_ap = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        wr(2'd0, 8'd2);
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("coinc_tick0_r%0d", i + 17), 32'(tick_out[0]), 32'(tk_ap[i]));
            check($sformatf("coinc_pend0_r%0d", i + 17), 32'(pending_out[0]), 32'(pd_ap[i]));
            if (i == 0) wr(2'd0, 8'd1);
            if (i == 1) div_wr = 1'b0;
            if (i == 7) wr(2'd1, 8'd6);
        end
        div_wr = 1'b0;

        // ---------------- async reset mid-period for half a clock ----------
        check("pre_rst_pend", 32'(pending_out), 32'd2);
        check("pre_rst_tick", 32'(tick_out), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_tick", 32'(tick_out), 32'd0);
        check("async_rst_sq",   32'(sq_out),   32'd0);
        check("async_rst_pend", 32'(pending_out), 32'd0);
        #4 rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            check($sformatf("post_rst_tick_e%0d", e), 32'(tick_out), (e % 2 == 0) ? 32'd3 : 32'd0);
            check($sformatf("post_rst_pend_e%0d", e), 32'(pending_out), 32'd0);
            check($sformatf("post_rst_sq_e%0d", e), 32'(sq_out), 32'(sqx((e >= 2 && e <= 3) ? 2'b11 : 2'b00)));
        end

        // ---------------- D = 2^WIDTH-1: period 2^WIDTH ---------------------
        wr(2'd0, 8'd255);
        step();
        div_wr       = 1'b0;
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        first_tick = 0;
        for (int e = 1; e <= 300; e++) begin
            step();
            if (tick_out[0] && first_tick == 0) first_tick = e;
            if (first_tick != 0) break;
        end
        check("dmax_first_tick_edge", 32'(first_tick), 32'd256);
        step();
        check("dmax_tick_one_cycle", 32'(tick_out[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_multi_tick_divider
